// File: rtl/onehot_encoder_q.sv
// Sticky one-hot request collector: queues pending request bits and emits one
// binary select code per valid/ready handshake, lowest index first.
module onehot_encoder_q #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         clr_err,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic         out_multi,
    output logic [N-1:0] pend,
    output logic         dup_err
);

    typedef enum logic {IDLE, VALID} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] grant_clear;
    logic [W-1:0] code_q, code_d;
    logic         multi_q, multi_d;
    logic         valid_q, valid_d;
    logic         dup_q, dup_d;
    logic [W-1:0] low_idx;
    logic [N-1:0] low_oh;
    logic         found;
    logic         load;

    // Lowest set bit of the registered pending vector (bit 0 has priority)
    always_comb begin
        low_idx = '0;
        low_oh  = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend_q[i] && !found) begin
                found     = 1'b1;
                low_idx   = W'(i);
                low_oh[i] = 1'b1;
            end
        end
    end

    // Next-state, load decision and next register values
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        multi_d     = multi_q;
        grant_clear = '0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    load    = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    load    = |pend_q;
                    state_d = (|pend_q) ? VALID : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            code_d      = low_idx;
            multi_d     = |(pend_q & (pend_q - N'(1)));
            grant_clear = low_oh;
        end

        valid_d = (state_d == VALID);
        // A new request on a bit being granted this edge re-arms it
        pend_d  = (pend_q & ~grant_clear) | req_in;
        dup_d   = (dup_q & ~clr_err) | (|(req_in & pend_q & ~grant_clear));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            multi_q <= multi_d;
            valid_q <= valid_d;
            dup_q   <= dup_d;
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign out_multi = multi_q;
    assign pend      = pend_q;
    assign dup_err   = dup_q;

endmodule

// File: tb/tb_onehot_encoder_q.sv
// Scoreboard bench for onehot_encoder_q: directed scenarios plus random traffic
// against a set-based reference model.
module tb_onehot_encoder_q;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_in;
    logic         clr_err;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_code;
    logic         out_multi;
    logic [N-1:0] pend;
    logic         dup_err;

    onehot_encoder_q #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .clr_err   (clr_err),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_multi (out_multi),
        .pend      (pend),
        .dup_err   (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] code;
        logic         multi;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    // Reference model: set of pending request indices and an output-held flag
    bit           m_pend[N];
    bit           m_valid;
    bit           m_dup;
    logic [N-1:0] mon_pend  = '0;
    logic         mon_dup   = 1'b0;
    logic         mon_valid = 1'b0;
    bit           mon_en    = 1'b0;

    function automatic logic [N-1:0] pack_pend();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_dup   = 1'b0;
        sb_q.delete();
    endtask

    // One clock of stimulus; the model predicts the effect of the coming edge
    task automatic drive(input logic [N-1:0] req, input logic rdy, input logic clr);
        int cnt;
        int low;
        bit load;
        bit dup;
        exp_t e;
        @(negedge clk);
        #1;
        mon_pend  = pack_pend();
        mon_dup   = m_dup;
        mon_valid = m_valid;
        req_in    = req;
        out_ready = rdy;
        clr_err   = clr;

        cnt = 0;
        low = -1;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) begin
                cnt++;
                if (low < 0) low = i;
            end
        end
        load = (cnt > 0) && (!m_valid || rdy);
        if (load) begin
            e.code  = W'(low);
            e.multi = (cnt > 1);
            sb_q.push_back(e);
            m_pend[low] = 1'b0;
        end
        dup = 1'b0;
        for (int j = 0; j < N; j++) if (req[j] && m_pend[j]) dup = 1'b1;
        m_dup = (m_dup && !clr) || dup;
        for (int j = 0; j < N; j++) if (req[j]) m_pend[j] = 1'b1;
        m_valid = load || (m_valid && !rdy);
    endtask

    // Monitor: compares presented outputs with the scoreboard head, pops on handshake
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("pend", int'(pend), int'(mon_pend));
                check("dup_err", int'(dup_err), int'(mon_dup));
                check("out_valid", int'(out_valid), int'(mon_valid));
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_code: got code %0d, expected no output", out_code);
                    end else begin
                        check("out_code", int'(out_code), int'(sb_q[0].code));
                        check("out_multi", int'(out_multi), int'(sb_q[0].multi));
                        if (out_ready) void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drain();
        repeat (N + 3) drive('0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_in    = '0;
        clr_err   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_valid", int'(out_valid), 0);
        check("reset_code", int'(out_code), 0);
        check("reset_multi", int'(out_multi), 0);
        check("reset_pend", int'(pend), 0);
        check("reset_dup", int'(dup_err), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single request, immediate accept
        drive(4'b0100, 1'b1, 1'b0);
        drain();
        // Three requests emitted back to back, lowest first
        drive(4'b1011, 1'b1, 1'b0);
        drain();
        // Held output under backpressure
        drive(4'b0001, 1'b0, 1'b0);
        repeat (5) drive('0, 1'b0, 1'b0);
        drain();
        // Duplicate request on a pending bit, then clear
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b1);
        drain();
        // Re-request on the bit being granted: no loss, no dup
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0001, 1'b1, 1'b0);
        drain();
        // clr_err coinciding with a new duplicate keeps the flag
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        drain();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom_range(0, 15));
            drive(r, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end
        drain();
        @(negedge clk);
        #3;
        check("scoreboard_empty", sb_q.size(), 0);

        // Asynchronous reset while a code is held and requests are pending
        drive(4'b1101, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_code", int'(out_code), 0);
        check("async_rst_multi", int'(out_multi), 0);
        check("async_rst_pend", int'(pend), 0);
        check("async_rst_dup", int'(dup_err), 0);
        model_reset();
        mon_pend  = '0;
        mon_dup   = 1'b0;
        mon_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;
        repeat (6) drive('0, 1'b1, 1'b0);
        @(negedge clk);
        #3;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
